// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C byte master: FSM state encoding and bus constants.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        START    = 4'd1,
        ADDR     = 4'd2,
        ADDR_ACK = 4'd3,
        WR_DATA  = 4'd4,
        WR_ACK   = 4'd5,
        RD_DATA  = 4'd6,
        RD_NACK  = 4'd7,
        STOP     = 4'd8
    } i2c_state_e;

    localparam logic       RW_READ     = 1'b1;
    localparam logic       RW_WRITE    = 1'b0;
    localparam logic [6:0] SWITCH_ADDR = 7'h57;

endpackage

// File: rtl/i2c_clk_tick.sv
// Quarter-period tick generator: one-cycle pulse every SCL_DIV clocks while enabled.
module i2c_clk_tick #(
    parameter int unsigned SCL_DIV = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int unsigned CW = $clog2(SCL_DIV);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(SCL_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_byte_master.sv
// Single-byte I2C master: START, {addr,rw}, one data byte (write or read), STOP.
// SCL is push-pull; SDA is open-drain; all bus activity advances on quarter ticks.
module i2c_byte_master #(
    parameter int unsigned SCL_DIV = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] slave_addr,
    input  logic       rw,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic       scl,
    inout  logic       sda,
    output logic [3:0] debug_state
);
    import i2c_pkg::*;

    i2c_state_e state, state_n;
    logic [1:0] q, q_n;
    logic [2:0] bit_idx, bit_n;
    logic       accept, tick;
    logic [7:0] addr_q, wr_q, rx_sh;
    logic [1:0] sda_sync;
    logic       ack_s, nack_seen;
    logic       sda_drv, sda_oe;
    logic       slot_scl;

    assign busy        = (state != IDLE);
    assign debug_state = state;
    assign sda         = sda_oe ? 1'b0 : 1'bz;
    assign slot_scl    = q[0] ^ q[1];

    i2c_clk_tick #(.SCL_DIV(SCL_DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (busy),
        .clr  (accept),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            q       <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_n;
            q       <= q_n;
            bit_idx <= bit_n;
        end
    end

    always_comb begin
        state_n = state;
        q_n     = q;
        bit_n   = bit_idx;
        accept  = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                accept  = 1'b1;
                state_n = START;
                q_n     = '0;
                bit_n   = '0;
            end
        end else if (tick) begin
            q_n = q + 2'd1;
            case (state)
                START: if (q == 2'd1) begin state_n = ADDR; q_n = '0; end
                STOP:  if (q == 2'd2) begin state_n = IDLE; q_n = '0; end
                default: begin
                    if (q == 2'd3) begin
                        bit_n = bit_idx + 3'd1;
                        case (state)
                            ADDR:     if (bit_idx == 3'd7) state_n = ADDR_ACK;
                            WR_DATA:  if (bit_idx == 3'd7) state_n = WR_ACK;
                            RD_DATA:  if (bit_idx == 3'd7) state_n = RD_NACK;
                            ADDR_ACK: begin
                                bit_n   = '0;
                                state_n = ack_s ? STOP : (addr_q[0] ? RD_DATA : WR_DATA);
                            end
                            default: begin
                                bit_n   = '0;
                                state_n = STOP;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    always_comb begin
        scl     = 1'b1;
        sda_drv = 1'b0;
        case (state)
            START:   sda_drv = (q == 2'd1);
            ADDR:    begin scl = slot_scl; sda_drv = ~addr_q[3'd7 - bit_idx]; end
            WR_DATA: begin scl = slot_scl; sda_drv = ~wr_q[3'd7 - bit_idx]; end
            ADDR_ACK, WR_ACK, RD_DATA, RD_NACK: scl = slot_scl;
            STOP:    begin scl = (q != 2'd0); sda_drv = (q != 2'd2); end
            default: ;
        endcase
    end

    // SDA is registered one clock behind SCL so a data change never coincides
    // with the SCL falling edge at a quarter boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_oe    <= 1'b0;
            sda_sync  <= '1;
            addr_q    <= '0;
            wr_q      <= '0;
            rx_sh     <= '0;
            rd_data   <= '0;
            ack_s     <= 1'b0;
            nack_seen <= 1'b0;
            ack_error <= 1'b0;
            done      <= 1'b0;
        end else begin
            done     <= 1'b0;
            sda_oe   <= sda_drv;
            sda_sync <= {sda_sync[0], sda};
            if (accept) begin
                addr_q    <= {slave_addr, rw};
                wr_q      <= wr_data;
                ack_error <= 1'b0;
                nack_seen <= 1'b0;
            end
            if (tick && q == 2'd2) begin
                ack_s <= sda_sync[1];
                if (state == RD_DATA) rx_sh <= {rx_sh[6:0], sda_sync[1]};
                if ((state == ADDR_ACK || state == WR_ACK) && sda_sync[1]) nack_seen <= 1'b1;
            end
            if (tick && q == 2'd3 && state == RD_DATA && bit_idx == 3'd7) rd_data <= rx_sh;
            if (tick && q == 2'd2 && state == STOP) begin
                done      <= 1'b1;
                ack_error <= nack_seen;
            end
        end
    end

endmodule

// File: doc/i2c_byte_master.md
I2C_BYTE_MASTER -- requirements
Module: i2c_byte_master

Interface
REQ-001 SHALL have parameter SCL_DIV, default 250: clk cycles per SCL quarter-period (100 MHz / (4*250) = 100 kHz); legal range >= 2.
REQ-002 SHALL have port clk, input, 1: 100 MHz system clock, the single clock domain.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1: single-cycle transaction request, sampled only when busy=0.
REQ-005 SHALL have port slave_addr, input, 7: target address (e.g. 7'h57 for the switch slave), captured on the accepted start.
REQ-006 SHALL have port rw, input, 1: 1 = read, 0 = write; captured on the accepted start.
REQ-007 SHALL have port wr_data, input, 8: write byte, captured on the accepted start.
REQ-008 SHALL have port rd_data, output, 8: last byte read; holds its value until the next read completes.
REQ-009 SHALL have port busy, output, 1: high from the cycle after an accepted start until done.
REQ-010 SHALL have port done, output, 1: one-cycle pulse at transaction end.
REQ-011 SHALL have port ack_error, output, 1: set with done when any slave ACK slot reads 1; held until the next accepted start.
REQ-012 SHALL have port scl, output, 1: I2C clock, push-pull.
REQ-013 SHALL have port sda, inout, 1: I2C data, open-drain (drive 0 or Z only).
REQ-014 SHALL have port debug_state, output, 4: current FSM state encoding.

Function
REQ-015 SHALL generate a one-cycle quarter tick every SCL_DIV clk cycles while busy; all bus activity advances only on ticks; the tick counter is cleared on an accepted start.
REQ-016 SHALL sample sda through a 2-flop synchronizer; sampling occurs at the tick ending quarter Q2 (SCL high).
REQ-017 SHALL use FSM states IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_NACK, STOP, with encodings 0..8 in that order.
REQ-018 START SHALL last 2 quarters with SCL=1: Q0 SDA released, Q1 SDA low.
REQ-019 Each bit slot SHALL last 4 quarters: Q0 SCL=0 with SDA set up; Q1 SCL=1; Q2 SCL=1 with sample at end; Q3 SCL=0.
REQ-020 ADDR SHALL send {slave_addr, rw} MSB first as 8 bit slots, then ADDR_ACK releases SDA for 1 slot.
REQ-021 On ADDR_ACK sample 1, the FSM SHALL set ack_error and go to STOP.
REQ-022 On ADDR_ACK sample 0, the FSM SHALL go to WR_DATA if rw=0, else RD_DATA.
REQ-023 WR_DATA SHALL send wr_data MSB first as 8 slots; WR_ACK then samples the slave ACK (1 sets ack_error); the FSM then goes to STOP.
REQ-024 RD_DATA SHALL release SDA for 8 slots and shift the samples in MSB first; rd_data updates at the end of the 8th slot.
REQ-025 RD_NACK SHALL release SDA (NACK) for 1 slot, then go to STOP.
REQ-026 STOP SHALL last 3 quarters: SCL=0/SDA low, SCL=1/SDA low, SCL=1/SDA released.
REQ-027 Leaving STOP SHALL pulse done, drop busy and return to IDLE.
REQ-028 Total bus length SHALL be 77 quarters for a full transaction and 41 quarters for an address NACK.
REQ-029 start while busy=1 SHALL be ignored, with no queuing.
REQ-030 In IDLE, scl SHALL be 1 and sda released.
REQ-031 Clock stretching and arbitration SHALL NOT be supported; SCL is never read back.

Reset
REQ-032 While rst_n=0 the block SHALL force: state=IDLE, scl=1, sda released, busy=0, done=0, ack_error=0, rd_data=8'h00, tick counter=0.
REQ-033 Reset asserted mid-transaction SHALL abort immediately with no STOP generated, returning to the values in REQ-032.

Structure
REQ-034 A shared package i2c_pkg SHALL hold the master state enum, the RW_READ=1 / RW_WRITE=0 constants and the SWITCH_ADDR=7'h57 constant.
REQ-035 The quarter-tick generator SHALL be sub-module i2c_clk_tick (parameter SCL_DIV; ports clk, rst_n, en, clr, tick).

Verification
REQ-036 With SCL_DIV=4, read addr 0x57 against a switch-slave model with SW=8'hA5 SHALL give rd_data=8'hA5, ack_error=0, and done within 77*4+4 cycles.
REQ-037 Write addr 0x57, wr_data 0x3C, against an ACKing slave model SHALL show 0xAE then 0x3C on the bus, ack_error=0.
REQ-038 Write to addr 0x22 with no slave present SHALL give ack_error=1, a STOP after the 9th slot, and done at quarter 41.
REQ-039 A start pulse at mid-transaction SHALL not change the bus waveform or the captured address/data.
REQ-040 rst_n low during RD_DATA bit 3 SHALL give scl=1, sda=Z, busy=0 in the same cycle; a following read SHALL succeed.
REQ-041 A protocol monitor SHALL confirm SDA changes only while SCL=0, except at START/STOP.
